// File: rtl/capture_readback_pkg.sv
// -----------------------------------------------------------------------------
// capture_readback_pkg
//   Shared definitions for the capture BRAM readback path: default widths for
//   the capture RAM and the readback FSM state encoding. The capture writer and
//   the logic-analyser top level import the same package so that everyone
//   agrees on the BRAM geometry.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package capture_readback_pkg;

  // Default capture RAM geometry: 2**18 words of 8 probe channels each.
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 8;

  // Default BRAM read latency (registered output, no extra pipeline stage).
  localparam int RD_LAT_DEF = 1;

  // Readback sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } rb_state_t;

endpackage

// File: rtl/capture_readback_if.sv
// -----------------------------------------------------------------------------
// capture_readback_if
//   Bundles the two data-carrying connections of the readback block:
//   the read side of the capture BRAM port and the valid/ready sample stream
//   towards the consumer (UART TX or host FIFO).
//   Signals:
//     bram_en   - BRAM read enable (driven by the readback block)
//     bram_addr - BRAM read address
//     bram_dout - BRAM read data, valid RD_LAT clocks after bram_en
//     m_data    - sample presented to the consumer
//     m_valid   - m_data valid
//     m_ready   - consumer accepts on m_valid && m_ready
//   Modports:
//     master - the readback block (drives enable/address and the stream)
//     slave  - BRAM plus consumer side
// -----------------------------------------------------------------------------
interface capture_readback_if
  import capture_readback_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output bram_en,
    output bram_addr,
    input  bram_dout,
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  bram_en,
    input  bram_addr,
    output bram_dout,
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/capture_readback.sv
// -----------------------------------------------------------------------------
// capture_readback
//   Streams the samples of a finished capture run out of the capture BRAM in
//   address order starting at 0. One word is fetched per transfer and held in
//   an output register until the consumer takes it, so backpressure never
//   needs a second read. The block only ever reads the shared BRAM port; the
//   top level guarantees it exclusive access while busy.
//
//   Parameters:
//     ADDR_W - BRAM address width (depth = 2**ADDR_W words)
//     DATA_W - sample width
//     RD_LAT - BRAM read latency in clocks (1..3)
//   Ports:
//     clk          - clock, rising edge
//     resetn       - asynchronous, active-low reset
//     start        - one-cycle pulse, begins a readback when idle
//     abort        - level, drops the run and returns to idle next cycle
//     num_samples  - words to read, sampled on start (clamped to the depth)
//     busy         - a run is in progress
//     done         - one-cycle pulse after the last word was accepted
//     rd_count     - words accepted downstream in the current or last run
//     bus          - BRAM read port and consumer stream (master modport)
// -----------------------------------------------------------------------------
module capture_readback
  import capture_readback_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W:0]    num_samples,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    rd_count,
  capture_readback_if.master bus
);

  // Full-depth length, one bit wider than the address so 2**ADDR_W fits.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // Value of the wait counter on the cycle bram_dout becomes valid.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  rb_state_t         state_q;
  rb_state_t         state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic [1:0]        wait_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              zero_done_q;

  logic              idle;
  logic              start_run;
  logic              start_empty;
  logic [ADDR_W:0]   len_clamped;
  logic              handshake;
  logic [ADDR_W:0]   cnt_inc;
  logic              last_word;
  logic              wait_done;

  // Decoded conditions shared by the next-state logic and the datapath.
  // abort always beats start, including a start that arrives while idle.
  assign idle        = (state_q == ST_IDLE);
  assign start_run   = start && !abort && idle && (num_samples != '0);
  assign start_empty = start && !abort && idle && (num_samples == '0);
  assign len_clamped = (num_samples > DEPTH) ? DEPTH : num_samples;
  assign handshake   = (state_q == ST_PRESENT) && valid_q && bus.m_ready;
  assign cnt_inc     = cnt_q + 1'b1;
  assign last_word   = (cnt_inc == len_q);
  assign wait_done   = (wait_q == WAIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An abort sends every state straight back to idle
  // without passing through DONE, so no done pulse is produced.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_run) begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_done) begin
            state_d = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (handshake) begin
            state_d = last_word ? ST_DONE : ST_FETCH;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: length latch, address/accept counters, read-latency counter and
  // the output holding register. m_data is only loaded in WAIT, so it cannot
  // move while a word is being presented.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      // An empty request is answered with a done pulse but never goes busy.
      zero_done_q <= start_empty;
      if (abort) begin
        valid_q <= 1'b0;
        wait_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_run) begin
              len_q  <= len_clamped;
              addr_q <= '0;
              cnt_q  <= '0;
            end
          end
          ST_FETCH: begin
            wait_q <= '0;
          end
          ST_WAIT: begin
            if (wait_done) begin
              data_q  <= bus.bram_dout;
              valid_q <= 1'b1;
            end else begin
              wait_q <= wait_q + 1'b1;
            end
          end
          ST_PRESENT: begin
            // After the final word of a full-depth run the address rolls to
            // 0, but DONE follows and no further read is issued.
            if (handshake) begin
              valid_q <= 1'b0;
              cnt_q   <= cnt_inc;
              addr_q  <= addr_q + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Outputs. The BRAM enable is a single cycle because FETCH always lasts
  // exactly one clock. busy covers DONE so it falls together with done.
  always_comb begin
    bus.bram_en   = (state_q == ST_FETCH);
    bus.bram_addr = addr_q;
    bus.m_data    = data_q;
    bus.m_valid   = valid_q;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE) || zero_done_q;
    rd_count      = cnt_q;
  end

endmodule

// File: tb/tb_capture_readback.sv
// -----------------------------------------------------------------------------
// tb_capture_readback
//   Drives three builds of capture_readback (ADDR_W=4, RD_LAT=1,2,3) from one
//   shared stimulus stream. Each lane has its own BRAM latency pipe and a
//   timeline model that predicts every output from the transfer rules:
//   a word appears RD_LAT+2 clocks after start or after the previous accept,
//   the word presented is mem[words accepted so far], done follows the last
//   accept by one clock. Directed literal expectations on lane 0 pin the model.
// -----------------------------------------------------------------------------
module tb_capture_readback;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NL = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW:0]   num_samples = '0;

  logic [DW-1:0] mem [16];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [NL-1:0] busy_v;
  logic [NL-1:0] done_v;
  logic [NL-1:0] valid_v;
  logic [NL-1:0] en_v;
  logic [AW:0]   cnt_a  [NL];
  logic [AW-1:0] addr_a [NL];
  logic [DW-1:0] data_a [NL];

  int            done_cnt [NL];
  int            en_cnt   [NL];
  logic [DW-1:0] got0[$];
  int            hs_cyc0[$];
  int            addr0[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar k = 0; k < NL; k++) begin : g_lane
    localparam int L = k + 1;

    capture_readback_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic          busy;
    logic          done;
    logic [AW:0]   rd_count;
    logic [DW-1:0] pipe [L];

    capture_readback #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .abort       (abort),
      .num_samples (num_samples),
      .busy        (busy),
      .done        (done),
      .rd_count    (rd_count),
      .bus         (bus)
    );

    assign bus.m_ready   = m_ready;
    assign bus.bram_dout = pipe[L-1];
    assign busy_v[k]     = busy;
    assign done_v[k]     = done;
    assign valid_v[k]    = bus.m_valid;
    assign en_v[k]       = bus.bram_en;
    assign cnt_a[k]      = rd_count;
    assign addr_a[k]     = bus.bram_addr;
    assign data_a[k]     = bus.m_data;

    // BRAM with RD_LAT-deep output pipe; EE marks cycles with no read.
    always @(posedge clk) begin
      pipe[0] <= bus.bram_en ? mem[bus.bram_addr] : 8'hEE;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    // Timeline model and per-cycle compare.
    bit act = 0;
    bit fin = 0;
    int len = 0;
    int acc = 0;
    int vdue = 0;
    int done_at = -1;

    initial begin
      done_cnt[k] = 0;
      en_cnt[k] = 0;
    end

    always @(negedge clk) begin
      bit exp_valid;
      bit exp_en;
      int n;
      if (!resetn) begin
        check_output($sformatf("L%0d rst m_valid", L), bus.m_valid, 0);
        check_output($sformatf("L%0d rst bram_en", L), bus.bram_en, 0);
        check_output($sformatf("L%0d rst busy", L), busy, 0);
        check_output($sformatf("L%0d rst done", L), done, 0);
        check_output($sformatf("L%0d rst rd_count", L), rd_count, 0);
        check_output($sformatf("L%0d rst m_data", L), bus.m_data, 0);
        act = 0; fin = 0; len = 0; acc = 0; vdue = 0; done_at = -1;
      end else begin
        exp_valid = act && !fin && (cyc >= vdue);
        exp_en    = act && !fin && (cyc == vdue - L - 1);
        check_output($sformatf("L%0d m_valid", L), bus.m_valid, exp_valid);
        check_output($sformatf("L%0d bram_en", L), bus.bram_en, exp_en);
        check_output($sformatf("L%0d busy", L), busy, act);
        check_output($sformatf("L%0d done", L), done, cyc == done_at);
        check_output($sformatf("L%0d rd_count", L), rd_count, acc);
        if (exp_valid) check_output($sformatf("L%0d m_data", L), bus.m_data, mem[acc]);
        if (exp_en) check_output($sformatf("L%0d bram_addr", L), bus.bram_addr, acc);

        if (done) done_cnt[k]++;
        if (bus.bram_en) en_cnt[k]++;
        if (k == 0 && bus.bram_en) addr0.push_back(int'(bus.bram_addr));
        if (k == 0 && bus.m_valid && m_ready) begin
          got0.push_back(bus.m_data);
          hs_cyc0.push_back(cyc);
        end

        if (abort) begin
          act = 0; fin = 0; done_at = -1;
        end else if (act) begin
          if (cyc == done_at) begin
            act = 0; fin = 0;
          end else if (exp_valid && m_ready) begin
            acc++;
            if (acc == len) begin
              fin = 1;
              done_at = cyc + 1;
            end else begin
              vdue = cyc + L + 2;
            end
          end
        end else if (start) begin
          n = (int'(num_samples) > 16) ? 16 : int'(num_samples);
          if (n == 0) begin
            done_at = cyc + 1;
          end else begin
            act = 1; fin = 0; len = n; acc = 0; vdue = cyc + L + 2;
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [AW:0] n);
    num_samples = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_all_idle(input string name);
    int b = 0;
    while ((busy_v != '0 || done_v != '0) && b < 500) begin
      tick();
      b++;
    end
    check_output({name, " idle timeout"}, b < 500, 1);
    tick(2);
  endtask

  task automatic wait_valid0(input string name);
    int b = 0;
    while (!valid_v[0] && b < 100) begin
      tick();
      b++;
    end
    check_output(name, valid_v[0], 1);
  endtask

  task automatic wait_cnt0(input string name, input int c);
    int b = 0;
    while (int'(cnt_a[0]) != c && b < 200) begin
      tick();
      b++;
    end
    check_output(name, cnt_a[0], c);
  endtask

  initial begin
    int lat;
    int d0;
    int e0;
    logic [DW-1:0] exp4 [4];

    mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'hFF; mem[3] = 8'h00;
    for (int i = 4; i < 16; i++) mem[i] = 8'(8'h10 + i);

    tick(3);
    check_output("reset busy", busy_v, 0);
    check_output("reset m_valid", valid_v, 0);
    check_output("reset rd_count", cnt_a[0], 0);
    resetn = 1'b1;
    tick(2);

    // Scenario 1: four words, consumer always ready.
    $display("[TB] scenario 1: basic stream");
    m_ready = 1'b1;
    got0.delete(); hs_cyc0.delete();
    d0 = done_cnt[0];
    apply_stimulus(5'd4);
    lat = 0;
    while (!valid_v[0] && lat < 20) begin
      tick();
      lat++;
    end
    check_output("s1 first valid latency", lat, 2);
    wait_all_idle("s1");
    check_output("s1 words", got0.size(), 4);
    exp4 = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    for (int i = 0; i < 4 && i < got0.size(); i++)
      check_output($sformatf("s1 word%0d", i), got0[i], exp4[i]);
    if (hs_cyc0.size() >= 2) check_output("s1 throughput", hs_cyc0[1] - hs_cyc0[0], 3);
    for (int k = 0; k < NL; k++) check_output($sformatf("s1 rd_count L%0d", k + 1), cnt_a[k], 4);
    check_output("s1 done pulses", done_cnt[0] - d0, 1);

    // Scenario 2: backpressure on word 1.
    $display("[TB] scenario 2: backpressure");
    got0.delete();
    apply_stimulus(5'd3);
    wait_cnt0("s2 first accept", 1);
    m_ready = 1'b0;
    wait_valid0("s2 word1 presented");
    for (int i = 0; i < 10; i++) begin
      check_output("s2 held valid", valid_v[0], 1);
      check_output("s2 held data", data_a[0], 8'h5A);
      check_output("s2 held addr", addr_a[0], 1);
      check_output("s2 no fetch", en_v[0], 0);
      tick();
    end
    m_ready = 1'b1;
    wait_all_idle("s2");
    check_output("s2 rd_count", cnt_a[0], 3);
    check_output("s2 words", got0.size(), 3);
    if (got0.size() == 3) check_output("s2 last word", got0[2], 8'hFF);

    // Scenario 3: empty request.
    $display("[TB] scenario 3: zero length");
    e0 = en_cnt[0];
    d0 = done_cnt[0];
    apply_stimulus(5'd0);
    check_output("s3 done", done_v[0], 1);
    check_output("s3 busy", busy_v[0], 0);
    tick();
    check_output("s3 done cleared", done_v[0], 0);
    check_output("s3 no bram_en", en_cnt[0] - e0, 0);
    check_output("s3 done pulses", done_cnt[0] - d0, 1);
    tick(2);

    // Scenario 4: abort after the third accept.
    $display("[TB] scenario 4: abort");
    d0 = done_cnt[0];
    apply_stimulus(5'd8);
    wait_cnt0("s4 third accept", 3);
    m_ready = 1'b0;
    wait_valid0("s4 word3 presented");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("s4 m_valid", valid_v[0], 0);
    check_output("s4 busy", busy_v[0], 0);
    check_output("s4 bram_en", en_v[0], 0);
    check_output("s4 rd_count", cnt_a[0], 3);
    tick(3);
    check_output("s4 no done", done_cnt[0] - d0, 0);
    m_ready = 1'b1;
    wait_all_idle("s4");
    got0.delete(); addr0.delete();
    apply_stimulus(5'd2);
    wait_all_idle("s4 restart");
    check_output("s4 restart words", got0.size(), 2);
    if (got0.size() > 0) check_output("s4 restart word0", got0[0], 8'hA5);
    if (addr0.size() > 0) check_output("s4 restart addr", addr0[0], 0);
    check_output("s4 restart rd_count", cnt_a[0], 2);

    // Scenario 5: full depth and clamping.
    $display("[TB] scenario 5: full depth");
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 13 + 7);
    got0.delete(); addr0.delete();
    d0 = done_cnt[0];
    apply_stimulus(5'd16);
    wait_all_idle("s5");
    for (int k = 0; k < NL; k++) check_output($sformatf("s5 rd_count L%0d", k + 1), cnt_a[k], 16);
    check_output("s5 addr count", addr0.size(), 16);
    for (int i = 0; i < 16 && i < addr0.size(); i++)
      check_output($sformatf("s5 addr%0d", i), addr0[i], i);
    check_output("s5 last word", got0.size() == 16 ? got0[15] : 8'h00, 8'hCA);
    check_output("s5 done pulses", done_cnt[0] - d0, 1);
    got0.delete();
    apply_stimulus(5'd20);
    wait_all_idle("s5 clamp");
    check_output("s5 clamp rd_count", cnt_a[0], 16);
    check_output("s5 clamp words", got0.size(), 16);

    // Scenario 6: start while busy, then reset mid-run.
    $display("[TB] scenario 6: start while busy and reset");
    got0.delete();
    apply_stimulus(5'd4);
    num_samples = 5'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_all_idle("s6");
    check_output("s6 rd_count", cnt_a[0], 4);
    check_output("s6 words", got0.size(), 4);
    if (got0.size() == 4) check_output("s6 word3", got0[3], 8'h2E);
    d0 = done_cnt[0];
    m_ready = 1'b0;
    apply_stimulus(5'd4);
    wait_valid0("s6 presenting");
    resetn = 1'b0;
    #1;
    check_output("s6 rst m_valid", valid_v[0], 0);
    check_output("s6 rst busy", busy_v[0], 0);
    check_output("s6 rst done", done_v[0], 0);
    check_output("s6 rst bram_en", en_v[0], 0);
    check_output("s6 rst rd_count", cnt_a[0], 0);
    check_output("s6 rst m_data", data_a[0], 0);
    check_output("s6 rst bram_addr", addr_a[0], 0);
    tick(2);
    resetn = 1'b1;
    m_ready = 1'b1;
    tick(5);
    check_output("s6 stays idle", busy_v, 0);
    check_output("s6 no partial done", done_cnt[0] - d0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
